// File: rtl/gf180mcu_fd_sc_mcu7t5v0__decap_pkg.sv
// Shared types and helpers for the sequenced decap bank controller.
package gf180mcu_fd_sc_mcu7t5v0__decap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN,
    SETTLE
  } state_t;

  function automatic int unsigned clog2w(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__decap_step_tmr.sv
// 8-bit down-counting step/settle timer; expired flags the final cycle of a loaded interval.
module gf180mcu_fd_sc_mcu7t5v0__decap_step_tmr (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       expired
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // A load of N expires on the Nth following edge; a load of 0 or 1 expires on the next one.
  assign expired = (cnt_q <= 8'd1);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__decap_bank_seq.sv
// Sequenced fillcap bank switcher: ramps a thermometer enable one bank per step toward a target.
module gf180mcu_fd_sc_mcu7t5v0__decap_bank_seq
  import gf180mcu_fd_sc_mcu7t5v0__decap_pkg::*;
#(
  parameter  int NBANK      = 8,
  parameter  int STEP_CYC   = 4,
  parameter  int SETTLE_CYC = 2,
  localparam int LW         = clog2w(32'(NBANK) + 32'd1)
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VLD,
  input  logic [LW-1:0]    REQ_LVL,
  output logic             REQ_RDY,
  input  logic             ABORT,
  output logic [NBANK-1:0] EN,
  output logic [LW-1:0]    LVL,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [7:0]    STEP8 = 8'(STEP_CYC);
  localparam logic [7:0]    SET8  = 8'(SETTLE_CYC);
  localparam logic [LW-1:0] NB_L  = LW'(NBANK);

  state_t        state_q, state_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [LW-1:0] tgt_q, tgt_d;
  logic          done_q, done_d;
  logic          eq_q, eq_d;
  logic [LW-1:0] req_tgt;
  logic          tmr_load;
  logic [7:0]    tmr_val;
  logic          tmr_exp;

  gf180mcu_fd_sc_mcu7t5v0__decap_step_tmr u_tmr (
    .clk      (CLK),
    .rst      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    lvl_d    = lvl_q;
    tgt_d    = tgt_q;
    done_d   = 1'b0;
    eq_d     = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = STEP8;
    req_tgt  = (REQ_LVL > NB_L) ? NB_L : REQ_LVL;
    if (ABORT) begin
      state_d  = SETTLE;
      lvl_d    = '0;
      tgt_d    = '0;
      tmr_load = 1'b1;
      tmr_val  = SET8;
    end else begin
      case (state_q)
        IDLE: begin
          // A no-change request completes one cycle later via eq_q.
          done_d = eq_q;
          if (REQ_VLD) begin
            tgt_d = req_tgt;
            if (req_tgt > lvl_q) begin
              state_d  = RAMP_UP;
              tmr_load = 1'b1;
            end else if (req_tgt < lvl_q) begin
              state_d  = RAMP_DOWN;
              tmr_load = 1'b1;
            end else begin
              eq_d = 1'b1;
            end
          end
        end
        RAMP_UP: begin
          if (tmr_exp) begin
            lvl_d    = lvl_q + LW'(1);
            tmr_load = 1'b1;
            if (lvl_d == tgt_q) begin
              state_d = SETTLE;
              tmr_val = SET8;
            end
          end
        end
        RAMP_DOWN: begin
          if (tmr_exp) begin
            lvl_d    = lvl_q - LW'(1);
            tmr_load = 1'b1;
            if (lvl_d == tgt_q) begin
              state_d = SETTLE;
              tmr_val = SET8;
            end
          end
        end
        SETTLE: begin
          if (tmr_exp) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      lvl_q   <= '0;
      tgt_q   <= '0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
    end
  end

  // Enables are derived from the level count, so EN is thermometer coded by construction.
  always_comb begin
    EN = '0;
    for (int unsigned i = 0; i < NBANK; i++) begin
      EN[i] = (i < 32'(lvl_q));
    end
  end

  assign LVL     = lvl_q;
  assign BUSY    = (state_q != IDLE);
  assign DONE    = done_q;
  assign REQ_RDY = (state_q == IDLE) && !ABORT;

`ifndef FUNCTIONAL
  specify
  endspecify
`endif

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__decap_bank_seq.md
GF180MCU_FD_SC_MCU7T5V0__DECAP_BANK_SEQ -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__decap_bank_seq

Interface
REQ-001 Parameter NBANK, default 8: number of switchable fillcap banks, range 1..32.
REQ-002 Parameter STEP_CYC, default 4: cycles between consecutive bank switch steps, range 1..255.
REQ-003 Parameter SETTLE_CYC, default 2: cycles held after the final step before completion, range 0..255.
REQ-004 Local width LW SHALL be clog2(NBANK+1).
REQ-005 CLK  input  1  sole clock, all state on rising edge.
REQ-006 RST  input  1  reset, synchronous, active-high.
REQ-007 VDD, VSS  inout  1  supply pins, present only under USE_POWER_PINS.
REQ-008 REQ_VLD  input  1  new target level offered.
REQ-009 REQ_LVL  input  LW  requested number of enabled banks.
REQ-010 REQ_RDY  output  1  request accepted when REQ_VLD and REQ_RDY are both high at a rising edge.
REQ-011 ABORT  input  1  emergency disable of all banks.
REQ-012 EN  output  NBANK  thermometer bank enables, bit 0 first on, last off.
REQ-013 LVL  output  LW  current count of set EN bits.
REQ-014 BUSY  output  1  high in any state other than IDLE.
REQ-015 DONE  output  1  one-cycle pulse on completion of a request or abort.

Function
REQ-016 FSM states SHALL be IDLE, RAMP_UP, RAMP_DOWN, SETTLE.
REQ-017 REQ_RDY SHALL be high only in IDLE with ABORT low.
REQ-018 On acceptance, target SHALL be min(REQ_LVL, NBANK).
REQ-019 Target greater than LVL -> RAMP_UP; less -> RAMP_DOWN; equal -> stay IDLE and pulse DONE the next cycle.
REQ-020 In a ramp state, the step timer SHALL count STEP_CYC cycles; EN changes by exactly one bit every STEP_CYC cycles, the first change occurring STEP_CYC edges after acceptance.
REQ-021 RAMP_UP SHALL set the lowest clear bit per step; RAMP_DOWN SHALL clear the highest set bit per step.
REQ-022 When LVL reaches target, the FSM SHALL enter SETTLE, hold EN for SETTLE_CYC cycles, then enter IDLE with DONE high in that same cycle.
REQ-023 With SETTLE_CYC=0, the FSM SHALL enter IDLE and pulse DONE on the edge after the final step.
REQ-024 EN SHALL always be thermometer coded, and LVL SHALL always equal popcount(EN).
REQ-025 REQ_VLD outside IDLE SHALL be ignored, without queueing.
REQ-026 ABORT high at an edge in any state SHALL clear EN to 0 on that edge and enter SETTLE with target 0; ABORT has priority over REQ_VLD.
REQ-027 ABORT held high SHALL keep EN at 0 and the FSM in SETTLE; completion follows REQ-022 after release.
REQ-028 The step timer SHALL reset on every state entry.

Reset
REQ-029 RST high at an edge SHALL force: state IDLE, EN=0, LVL=0, DONE=0, BUSY=0, timer=0, target=0; REQ_RDY then follows REQ-017.
REQ-030 RST SHALL override ABORT and REQ_VLD, including mid-ramp, with no DONE pulse.

Structure
REQ-031 Package gf180mcu_fd_sc_mcu7t5v0__decap_pkg SHALL hold the state enum and the clog2 width function.
REQ-032 Sub-module gf180mcu_fd_sc_mcu7t5v0__decap_step_tmr SHALL implement the 8-bit step/settle timer, with load, count, and expiry flag.
REQ-033 Under FUNCTIONAL undefined, the module SHALL contain an empty specify block.

Verification (NBANK=8, STEP_CYC=4, SETTLE_CYC=2)
REQ-034 From reset, REQ_LVL=5 accepted at edge t -> EN=0x01 at t+4, 0x03 at t+8 ... 0x1F at t+20; DONE at t+22; REQ_RDY high at t+22.
REQ-035 REQ_LVL=12 from LVL=0 -> clamp to 8; EN=0xFF at t+32; DONE at t+34.
REQ-036 LVL=8 with REQ_LVL=2 -> EN=0x7F at t+4 ... 0x03 at t+24; DONE at t+26; REQ_VLD pulses mid-ramp ignored.
REQ-037 ABORT at t+10 during a ramp to 5 (EN=0x03) -> EN=0 at t+10, DONE at t+12; REQ_LVL=3 in the same cycle is not accepted.
REQ-038 RST at t+9 during a ramp -> EN=0, BUSY=0, no DONE; REQ_LVL=3 when LVL=3 -> EN unchanged, DONE one cycle after acceptance.
